simon_sequencer: RTL and testbench
==================================

Name: simon_sequencer

Overview:
- Timed game sequencer for the Simon datapath. It replaces the free-running single-step control with one fast clock.
- It drives the datapath strobes (count/index counters, memory write, level latch, memory read) from a user submit pulse and internal dwell/gap timers.
- Result: playback and the win/lose display advance automatically at a visible rate.
- Sits between the board-level input conditioning (debounced submit pulse) and the datapath.

Parameters:
- DWELL_CYCLES, 4: cycles each stored pattern is shown during playback/done display.
- GAP_CYCLES, 2: blank cycles between shown patterns.
- TIMER_W, 8: timer width; DWELL_CYCLES and GAP_CYCLES must be ≤ 2^TIMER_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- submit  in  1  one-cycle pulse: user pattern valid on datapath pattern input.
- is_legal  in  1  datapath: current user pattern is legal.
- input_eq_pattern  in  1  datapath: user pattern equals memory[index].
- last_index  in  1  datapath: index == count-1.
- mem_full  in  1  datapath: count == memory depth.
- cnt_count  out  1  increment count.
- clr_count  out  1  clear count.
- cnt_index  out  1  increment index.
- clr_index  out  1  clear index.
- w_en  out  1  write pattern to memory[count].
- set_level  out  1  latch level switch.
- read_Memory  out  1  datapath displays memory[index] instead of user pattern.
- show_en  out  1  1 = pattern_leds lit; 0 = blank gap.
- mode_leds  out  3  001 input, 010 playback, 100 repeat, 111 done.

Behaviour:
- States: S_INIT, S_INPUT, S_PB_SHOW, S_PB_GAP, S_REPEAT, S_DN_SHOW, S_DN_GAP. State and timer are registered.
- Strobe outputs are decoded combinationally from state, inputs and timer. The datapath acts on them at the same rising edge as the state transition.
- Reset (rst=0, asynchronous): state=S_INIT, timer=0.
  - S_INIT outputs: clr_count=1, clr_index=1, set_level=1, mode_leds=001, all others 0.
  - Level is latched only here; reset mid-game returns to S_INIT immediately, regardless of state.
- S_INIT: unconditional → S_INPUT after one clock.
- S_INPUT (mode 001, read_Memory=0, show_en=1):
  - submit & is_legal: w_en=1, cnt_count=1, clr_index=1 → S_PB_SHOW, timer=0.
  - submit & !is_legal: ignored, stay.
- S_PB_SHOW (mode 010, read_Memory=1, show_en=1): timer increments; at timer==DWELL_CYCLES-1 → S_PB_GAP, timer=0.
- S_PB_GAP (mode 010, read_Memory=1, show_en=0): timer increments; at timer==GAP_CYCLES-1, timer=0 and:
  - last_index: clr_index=1 → S_REPEAT.
  - else: cnt_index=1 → S_PB_SHOW.
- S_REPEAT (mode 100, read_Memory=0, show_en=1), on submit:
  - !input_eq_pattern: clr_index=1 → S_DN_SHOW (lose).
  - match & !last_index: cnt_index=1, stay.
  - match & last_index: clr_index=1; mem_full → S_DN_SHOW (win), else → S_INPUT.
  - No submit: stay; no timeout.
- S_DN_SHOW / S_DN_GAP (mode 111, read_Memory=1): same timing as playback. At gap end, last_index gives clr_index=1, else cnt_index=1; this loops forever until reset.
- submit in S_INIT/PB/DN states is ignored; it is not queued.
- Never more than one of cnt_index/clr_index asserted per cycle. Same rule for cnt_count/clr_count.
- Timer is held at 0 in S_INIT/S_INPUT/S_REPEAT. Timer never wraps: the compare-to-limit comes first.
- DWELL_CYCLES=1 or GAP_CYCLES=1 is legal: one cycle per phase.

Test Plan:
- Reset release, no submit: S_INIT outputs set_level=1, clr_count=1, clr_index=1 for exactly one clk; then mode_leds=001, all strobes 0 indefinitely.
- submit with is_legal=1 in S_INPUT:
  - w_en=1 and cnt_count=1 for one cycle.
  - mode_leds=010; show_en high 4 cycles, low 2.
  - With last_index=1, clr_index pulses and mode_leds=100 at cycle 7 after submit.
- Playback with count=3 (last_index asserted while index==2): cnt_index pulses exactly twice at gap ends, then clr_index and REPEAT; total 18 cycles.
- REPEAT, three matching submits with last_index on the third, mem_full=0: cnt_index, cnt_index, clr_index, then mode_leds=001. Same with mem_full=1 → mode_leds=111.
- REPEAT, submit with input_eq_pattern=0: clr_index=1 → mode_leds=111; display loop wraps index continuously; submit pulses ignored.
- rst asserted mid-S_PB_SHOW (timer=2): outputs immediately show S_INIT values; after release set_level pulses again and timer restarts at 0.

Source files
------------

// File: rtl/simon_sequencer.sv
// Simon game sequencer: turns submit pulses and dwell/gap timers into
// datapath strobes so playback and the result display advance on one clock.
module simon_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       submit,
    input  logic       is_legal,
    input  logic       input_eq_pattern,
    input  logic       last_index,
    input  logic       mem_full,
    output logic       cnt_count,
    output logic       clr_count,
    output logic       cnt_index,
    output logic       clr_index,
    output logic       w_en,
    output logic       set_level,
    output logic       read_Memory,
    output logic       show_en,
    output logic [2:0] mode_leds
);

    typedef enum logic [2:0] {
        S_INIT,
        S_INPUT,
        S_PB_SHOW,
        S_PB_GAP,
        S_REPEAT,
        S_DN_SHOW,
        S_DN_GAP
    } state_t;

    localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);

    state_t             state;
    state_t             state_n;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_n;
    logic               dwell_done;
    logic               gap_done;

    assign dwell_done = (timer == DWELL_LAST);
    assign gap_done   = (timer == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_INIT;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // Limit compare precedes increment, so the timer can never wrap.
    always_comb begin
        state_n     = state;
        timer_n     = '0;
        cnt_count   = 1'b0;
        clr_count   = 1'b0;
        cnt_index   = 1'b0;
        clr_index   = 1'b0;
        w_en        = 1'b0;
        set_level   = 1'b0;
        read_Memory = 1'b0;
        show_en     = 1'b0;
        mode_leds   = 3'b001;
        unique case (state)
            S_INIT: begin
                clr_count = 1'b1;
                clr_index = 1'b1;
                set_level = 1'b1;
                state_n   = S_INPUT;
            end
            S_INPUT: begin
                show_en = 1'b1;
                if (submit && is_legal) begin
                    w_en      = 1'b1;
                    cnt_count = 1'b1;
                    clr_index = 1'b1;
                    state_n   = S_PB_SHOW;
                end
            end
            S_PB_SHOW, S_DN_SHOW: begin
                mode_leds   = (state == S_PB_SHOW) ? 3'b010 : 3'b111;
                read_Memory = 1'b1;
                show_en     = 1'b1;
                if (dwell_done)
                    state_n = (state == S_PB_SHOW) ? S_PB_GAP : S_DN_GAP;
                else
                    timer_n = timer + TIMER_W'(1);
            end
            S_PB_GAP, S_DN_GAP: begin
                mode_leds   = (state == S_PB_GAP) ? 3'b010 : 3'b111;
                read_Memory = 1'b1;
                if (gap_done) begin
                    clr_index = last_index;
                    cnt_index = !last_index;
                    if (state == S_DN_GAP)
                        state_n = S_DN_SHOW;
                    else if (last_index)
                        state_n = S_REPEAT;
                    else
                        state_n = S_PB_SHOW;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            S_REPEAT: begin
                mode_leds = 3'b100;
                show_en   = 1'b1;
                if (submit) begin
                    if (!input_eq_pattern) begin
                        clr_index = 1'b1;
                        state_n   = S_DN_SHOW;
                    end else if (!last_index) begin
                        cnt_index = 1'b1;
                    end else begin
                        clr_index = 1'b1;
                        state_n   = mem_full ? S_DN_SHOW : S_INPUT;
                    end
                end
            end
            default: state_n = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomized bench for simon_sequencer with a game-level model of
// the expected per-cycle output sequence and a small datapath model.
module tb_simon_sequencer;

    localparam int DW    = 4;
    localparam int GP    = 2;
    localparam int DEPTH = 3;

    // {mode[2:0], read, show, cnt_count, clr_count, cnt_index, clr_index, w_en, set_level}
    localparam logic [10:0] V_INIT    = 11'b001_0_0_0_1_0_1_0_1;
    localparam logic [10:0] V_IN      = 11'b001_0_1_0_0_0_0_0_0;
    localparam logic [10:0] V_IN_SUB  = 11'b001_0_1_1_0_0_1_1_0;
    localparam logic [10:0] V_PB_SHOW = 11'b010_1_1_0_0_0_0_0_0;
    localparam logic [10:0] V_PB_GAP  = 11'b010_1_0_0_0_0_0_0_0;
    localparam logic [10:0] V_RP      = 11'b100_0_1_0_0_0_0_0_0;
    localparam logic [10:0] V_DN_SHOW = 11'b111_1_1_0_0_0_0_0_0;
    localparam logic [10:0] V_DN_GAP  = 11'b111_1_0_0_0_0_0_0_0;
    localparam logic [10:0] B_CNT_IDX = 11'b000_0_0_0_0_1_0_0_0;
    localparam logic [10:0] B_CLR_IDX = 11'b000_0_0_0_0_0_1_0_0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       submit = 1'b0;
    logic       is_legal = 1'b0;
    logic       input_eq_pattern = 1'b0;
    logic       last_index = 1'b0;
    logic       mem_full = 1'b0;
    logic       cnt_count, clr_count, cnt_index, clr_index;
    logic       w_en, set_level, read_Memory, show_en;
    logic [2:0] mode_leds;

    int n_cmp = 0;
    int n_bad = 0;
    int count = 0;
    int index = 0;

    always #5 clk = ~clk;

    simon_sequencer #(
        .DWELL_CYCLES(DW),
        .GAP_CYCLES  (GP),
        .TIMER_W     (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .submit          (submit),
        .is_legal        (is_legal),
        .input_eq_pattern(input_eq_pattern),
        .last_index      (last_index),
        .mem_full        (mem_full),
        .cnt_count       (cnt_count),
        .clr_count       (clr_count),
        .cnt_index       (cnt_index),
        .clr_index       (clr_index),
        .w_en            (w_en),
        .set_level       (set_level),
        .read_Memory     (read_Memory),
        .show_en         (show_en),
        .mode_leds       (mode_leds)
    );

    wire [10:0] obs_w = {mode_leds, read_Memory, show_en, cnt_count,
                         clr_count, cnt_index, clr_index, w_en, set_level};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Drive one cycle from the datapath model, sample at negedge, and
    // advance the datapath model with the strobes the game rules expect.
    task automatic tick(input logic sub, input logic leg, input logic eq,
                        input logic [10:0] expv, output logic [10:0] obs);
        submit           = sub;
        is_legal         = leg;
        input_eq_pattern = eq;
        last_index       = (index == count - 1);
        mem_full         = (count == DEPTH);
        @(negedge clk);
        obs = obs_w;
        @(posedge clk);
        #1;
        if (expv[4]) count = 0;
        else if (expv[5]) count++;
        if (expv[2]) index = 0;
        else if (expv[3]) index++;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        submit = 1'b0;
        #1;
        if (obs_w !== V_INIT) begin
            n_bad++;
            $display("FAIL reset_async: got %b want %b", obs_w, V_INIT);
        end
        n_cmp++;
        repeat (2) @(posedge clk);
        #1;
        if (obs_w !== V_INIT) begin
            n_bad++;
            $display("FAIL reset_hold: got %b want %b", obs_w, V_INIT);
        end
        n_cmp++;
        rst = 1'b1;
        tick(rb(), rb(), rb(), V_INIT, obs);
        if (obs !== V_INIT) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", obs, V_INIT);
        end
        n_cmp++;
    endtask

    task automatic test_ignore_input(input int n);
        logic [10:0] obs;
        for (int i = 0; i < n; i++) begin
            tick(rb(), 1'b0, rb(), V_IN, obs);
            if (obs !== V_IN) begin
                n_bad++;
                $display("FAIL input_idle c%0d: got %b want %b", i, obs, V_IN);
            end
            n_cmp++;
        end
    endtask

    task automatic test_record();
        logic [10:0] obs;
        tick(1'b1, 1'b1, rb(), V_IN_SUB, obs);
        if (obs !== V_IN_SUB) begin
            n_bad++;
            $display("FAIL record: got %b want %b", obs, V_IN_SUB);
        end
        n_cmp++;
    endtask

    task automatic show_gap(input logic [10:0] vs, input logic [10:0] vg,
                            input string tag);
        logic [10:0] obs;
        logic [10:0] e;
        int          n;
        n = count;
        for (int k = 0; k < n; k++) begin
            for (int d = 0; d < DW; d++) begin
                tick(rb(), rb(), rb(), vs, obs);
                if (obs !== vs) begin
                    n_bad++;
                    $display("FAIL %s_show p%0d d%0d: got %b want %b",
                             tag, k, d, obs, vs);
                end
                n_cmp++;
            end
            for (int g = 0; g < GP; g++) begin
                e = vg;
                if (g == GP - 1) e = e | ((k == n - 1) ? B_CLR_IDX : B_CNT_IDX);
                tick(rb(), rb(), rb(), e, obs);
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL %s_gap p%0d g%0d: got %b want %b",
                             tag, k, g, obs, e);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_playback();
        show_gap(V_PB_SHOW, V_PB_GAP, "pb");
    endtask

    task automatic test_done_loop(input int loops);
        for (int l = 0; l < loops; l++) show_gap(V_DN_SHOW, V_DN_GAP, "dn");
    endtask

    task automatic test_repeat(input int fail_at);
        logic [10:0] obs;
        logic [10:0] e;
        int          n;
        n = count;
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(3, 0)) begin
                tick(1'b0, rb(), rb(), V_RP, obs);
                if (obs !== V_RP) begin
                    n_bad++;
                    $display("FAIL rep_wait: got %b want %b", obs, V_RP);
                end
                n_cmp++;
            end
            if (j == fail_at) begin
                e = V_RP | B_CLR_IDX;
                tick(1'b1, rb(), 1'b0, e, obs);
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL rep_lose j%0d: got %b want %b", j, obs, e);
                end
                n_cmp++;
                return;
            end
            e = V_RP | ((j == n - 1) ? B_CLR_IDX : B_CNT_IDX);
            tick(1'b1, rb(), 1'b1, e, obs);
            if (obs !== e) begin
                n_bad++;
                $display("FAIL rep_match j%0d: got %b want %b", j, obs, e);
            end
            n_cmp++;
        end
    endtask

    task automatic test_done_entry();
        logic [10:0] obs;
        tick(rb(), rb(), rb(), V_DN_SHOW, obs);
        if (obs !== V_DN_SHOW) begin
            n_bad++;
            $display("FAIL done_entry: got %b want %b", obs, V_DN_SHOW);
        end
        n_cmp++;
        for (int d = 1; d < DW; d++) tick(rb(), rb(), rb(), V_DN_SHOW, obs);
        for (int g = 0; g < GP; g++)
            tick(rb(), rb(), rb(),
                 V_DN_GAP | ((g == GP - 1) ?
                    ((count == 1) ? B_CLR_IDX : B_CNT_IDX) : 11'b0), obs);
    endtask

    task automatic test_reset_mid_show();
        logic [10:0] obs;
        test_record();
        for (int d = 0; d < 2; d++) begin
            tick(rb(), rb(), rb(), V_PB_SHOW, obs);
            if (obs !== V_PB_SHOW) begin
                n_bad++;
                $display("FAIL mid_show d%0d: got %b want %b", d, obs, V_PB_SHOW);
            end
            n_cmp++;
        end
        rst = 1'b0;
        #1;
        if (obs_w !== V_INIT) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want %b", obs_w, V_INIT);
        end
        n_cmp++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(rb(), rb(), rb(), V_INIT, obs);
        if (obs !== V_INIT) begin
            n_bad++;
            $display("FAIL mid_release: got %b want %b", obs, V_INIT);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_ignore_input(5);
        for (int r = 1; r <= DEPTH; r++) begin
            test_record();
            test_playback();
            test_repeat(-1);
            if (r < DEPTH) test_ignore_input(3);
        end
        test_done_loop(2);

        test_reset();
        test_ignore_input(2);
        test_record();
        test_playback();
        test_repeat(-1);
        test_ignore_input(2);
        test_record();
        test_playback();
        test_repeat(int'($urandom_range(1, 0)));
        test_done_loop(3);

        test_reset();
        test_ignore_input(2);
        test_reset_mid_show();
        test_ignore_input(2);
        test_record();
        test_playback();
        test_repeat(0);
        test_done_loop(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
